// File: rtl/mem_stall_ctrl.sv
// mem_stall_ctrl: data-memory access sequencer for an in-order pipeline.
// A load or store seen in EX/MEM is latched and issued to a variable-latency
// data memory. The pipeline is held until the memory acknowledges or the
// access times out. After that, a single DONE cycle lets the pipeline advance
// by exactly one instruction.
//
// Handshake: mem_req_o is raised the cycle after the access is seen and is
// held, with mem_we_o/mem_addr_o/mem_wdata_o frozen, until mem_ack_i is seen
// high on a posedge in WAIT. mem_ack_i is a single-cycle pulse, and
// mem_rdata_i is only meaningful in that cycle. An ack that arrives outside
// WAIT belongs to no outstanding access and is dropped.
module mem_stall_ctrl #(
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned CNT_W   = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             MemRead_i,
    input  logic             MemWrite_i,
    input  logic [31:0]      addr_i,
    input  logic [31:0]      wdata_i,
    input  logic             mem_ack_i,
    input  logic [31:0]      mem_rdata_i,
    output logic             mem_req_o,
    output logic             mem_we_o,
    output logic [31:0]      mem_addr_o,
    output logic [31:0]      mem_wdata_o,
    output logic             stall_o,
    output logic [31:0]      rdata_o,
    output logic             err_o,
    output logic [CNT_W-1:0] stall_cnt_o
);

    // The wait counter only has to reach TIMEOUT-1.
    localparam int unsigned WCNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [WCNT_W-1:0] WAIT_LAST = WCNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic               req_q, req_d;
    logic               we_q, we_d;
    logic [31:0]        addr_q, addr_d;
    logic [31:0]        wdata_q, wdata_d;
    logic [31:0]        rdata_q, rdata_d;
    logic               err_q, err_d;
    logic [WCNT_W-1:0]  wait_cnt_q, wait_cnt_d;
    logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;

    logic               access;
    logic               wait_expired;

    // A simultaneous read and write is handled as a store, because we follows MemWrite_i.
    assign access       = MemRead_i | MemWrite_i;
    assign wait_expired = (wait_cnt_q == WAIT_LAST);

    // Stall is combinational so the pipeline freezes in the very cycle the access is seen.
    always_comb begin
        stall_o = 1'b0;
        if (!rst_i) begin
            case (state_q)
                ST_IDLE: stall_o = access;
                ST_WAIT: stall_o = 1'b1;
                default: stall_o = 1'b0;
            endcase
        end
    end

    // Next-state and next-output logic of the access sequencer.
    always_comb begin
        state_d    = state_q;
        req_d      = req_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        err_d      = err_q;
        wait_cnt_d = wait_cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (access) begin
                    req_d      = 1'b1;
                    we_d       = MemWrite_i;
                    addr_d     = addr_i;
                    wdata_d    = wdata_i;
                    wait_cnt_d = '0;
                    state_d    = ST_WAIT;
                end
            end

            ST_WAIT: begin
                // If the ack lands on the last allowed cycle, the ack is checked first and wins.
                if (mem_ack_i) begin
                    req_d   = 1'b0;
                    if (!we_q) begin
                        rdata_d = mem_rdata_i;
                    end
                    state_d = ST_DONE;
                end else if (wait_expired) begin
                    req_d   = 1'b0;
                    err_d   = 1'b1;
                    if (!we_q) begin
                        rdata_d = '0;
                    end
                    state_d = ST_DONE;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end

            ST_DONE: begin
                // The pipeline advances this cycle, so EX/MEM still shows the
                // finished access and must not be sampled again.
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
                req_d   = 1'b0;
            end
        endcase
    end

    // State and registered outputs; an asynchronous reset drops an in-flight request at once.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            req_q      <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            err_q      <= 1'b0;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            req_q      <= req_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
            err_q      <= err_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    // Saturating count of stalled cycles.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall_o && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    // Performance counter register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign mem_req_o   = req_q;
    assign mem_we_o    = we_q;
    assign mem_addr_o  = addr_q;
    assign mem_wdata_o = wdata_q;
    assign rdata_o     = rdata_q;
    assign err_o       = err_q;
    assign stall_cnt_o = stall_cnt_q;

endmodule

// File: tb/tb_mem_stall_ctrl.sv
// Testbench for mem_stall_ctrl: directed and random loads and stores against
// a transaction-level reference model. The driver pushes one expected record
// for each access. The monitor pops that record when it sees the request
// complete, which is the falling edge of mem_req_o.
module tb_mem_stall_ctrl;

    localparam int unsigned TIMEOUT = 4;
    localparam int unsigned CNT_W   = 6;
    localparam int          CNT_MAX = (1 << CNT_W) - 1;

    // Clock and reset.
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic             mem_read, mem_write, mem_ack;
    logic [31:0]      addr, wdata, mem_rdata;
    logic             mem_req, mem_we, stall, err;
    logic [31:0]      mem_addr, mem_wdata, rdata;
    logic [CNT_W-1:0] stall_cnt;

    mem_stall_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .MemRead_i   (mem_read),
        .MemWrite_i  (mem_write),
        .addr_i      (addr),
        .wdata_i     (wdata),
        .mem_ack_i   (mem_ack),
        .mem_rdata_i (mem_rdata),
        .mem_req_o   (mem_req),
        .mem_we_o    (mem_we),
        .mem_addr_o  (mem_addr),
        .mem_wdata_o (mem_wdata),
        .stall_o     (stall),
        .rdata_o     (rdata),
        .err_o       (err),
        .stall_cnt_o (stall_cnt)
    );

    // Expected result of one access, as seen in its DONE cycle.
    typedef struct packed {
        logic [7:0]  stall_cycles;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        err;
        logic [31:0] cnt;
    } exp_t;

    exp_t exp_q[$];

    int vectors     = 0;
    int miscompares = 0;

    // Reference model state.
    logic [31:0] m_rdata = '0;
    logic        m_err   = 1'b0;
    int          m_cnt   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Driver tasks. Each one starts and ends 1 time unit after a posedge.
    // d = cycle of WAIT (1..TIMEOUT) that carries the ack; 0 = no ack (timeout).
    task automatic run_txn(input bit rd, input bit wr, input logic [31:0] a,
                           input logic [31:0] wd, input int d,
                           input logic [31:0] rdat, input bit stray_done);
        exp_t e;
        int   n;
        n = (d == 0) ? TIMEOUT : d;
        if (!wr) m_rdata = (d == 0) ? 32'h0 : rdat;
        if (d == 0) m_err = 1'b1;
        m_cnt = (m_cnt + 1 + n > CNT_MAX) ? CNT_MAX : m_cnt + 1 + n;
        e.stall_cycles = 8'(1 + n);
        e.we    = wr;
        e.addr  = a;
        e.wdata = wd;
        e.rdata = m_rdata;
        e.err   = m_err;
        e.cnt   = 32'(m_cnt);
        exp_q.push_back(e);

        mem_read = rd; mem_write = wr; addr = a; wdata = wd; mem_ack = 1'b0;
        @(posedge clk); #1;
        for (int i = 1; i <= n; i++) begin
            mem_ack   = (i == d);
            mem_rdata = (i == d) ? rdat : $urandom;
            @(posedge clk); #1;
        end
        // DONE cycle: EX/MEM still holds the access; a stray ack must be dropped.
        mem_ack   = stray_done;
        mem_rdata = $urandom;
        @(posedge clk); #1;
        mem_ack = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            mem_read = 1'b0; mem_write = 1'b0;
            mem_ack   = ($urandom_range(0, 3) == 0);
            mem_rdata = $urandom;
            addr = $urandom; wdata = $urandom;
            @(posedge clk); #1;
        end
        mem_ack = 1'b0;
    endtask

    // Monitor and scoreboard.
    logic        req_prev = 1'b0;
    int          stall_run = 0;
    logic        cap_we = 1'b0;
    logic [31:0] cap_addr = '0, cap_wdata = '0;
    logic        held = 1'b1;
    exp_t        got_e;

    always @(negedge clk) begin
        if (rst) begin
            req_prev  = 1'b0;
            stall_run = 0;
            held      = 1'b1;
        end else begin
            if (mem_req && !req_prev) begin
                cap_we = mem_we; cap_addr = mem_addr; cap_wdata = mem_wdata;
                held = 1'b1;
            end else if (mem_req && req_prev) begin
                if (mem_we !== cap_we || mem_addr !== cap_addr || mem_wdata !== cap_wdata)
                    held = 1'b0;
            end
            if (req_prev && !mem_req) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_done", 32'd1, 32'd0);
                end else begin
                    got_e = exp_q.pop_front();
                    chk("stall_cycles", 32'(stall_run), 32'(got_e.stall_cycles));
                    chk("stall_in_done", 32'(stall), 32'd0);
                    chk("mem_we", 32'(cap_we), 32'(got_e.we));
                    chk("mem_addr", cap_addr, got_e.addr);
                    chk("mem_wdata", cap_wdata, got_e.wdata);
                    chk("req_fields_held", 32'(held), 32'd1);
                    chk("rdata", rdata, got_e.rdata);
                    chk("err", 32'(err), 32'(got_e.err));
                    chk("stall_cnt", 32'(stall_cnt), got_e.cnt);
                end
                stall_run = 0;
            end else if (stall) begin
                stall_run++;
            end
            req_prev = mem_req;
        end
    end

    task automatic chk_all_zero(input string tag);
        chk({tag, "_req"}, 32'(mem_req), 32'd0);
        chk({tag, "_we"}, 32'(mem_we), 32'd0);
        chk({tag, "_addr"}, mem_addr, 32'd0);
        chk({tag, "_wdata"}, mem_wdata, 32'd0);
        chk({tag, "_rdata"}, rdata, 32'd0);
        chk({tag, "_err"}, 32'(err), 32'd0);
        chk({tag, "_stall_cnt"}, 32'(stall_cnt), 32'd0);
        chk({tag, "_stall"}, 32'(stall), 32'd0);
    endtask

    initial begin
        int k, d;
        mem_read = 1'b0; mem_write = 1'b0; mem_ack = 1'b0;
        addr = '0; wdata = '0; mem_rdata = '0;
        #1 rst = 1'b1;
        mem_read = 1'b1;            // stall must stay low while reset is held
        #1 chk_all_zero("reset");
        @(posedge clk); @(posedge clk); #1;
        mem_read = 1'b0;
        rst = 1'b0;
        idle(1);

        // Directed accesses.
        run_txn(1, 0, 32'h40, 32'h0, 3, 32'hDEADBEEF, 0);
        idle(1);
        run_txn(0, 1, 32'h44, 32'h12345678, 1, 32'hCAFEF00D, 0);
        run_txn(1, 0, 32'h4C, 32'h0, TIMEOUT, 32'h0BADF00D, 0);   // ack on last allowed cycle
        idle(2);
        run_txn(1, 0, 32'h48, 32'h0, 0, 32'h0, 0);                // timeout
        run_txn(1, 1, 32'h50, 32'hA5A5A5A5, 2, 32'h77777777, 0);  // both -> store
        run_txn(1, 0, 32'h54, 32'h0, 1, 32'h11111111, 1);         // back-to-back, stray ack in DONE
        run_txn(1, 0, 32'h58, 32'h0, 2, 32'h22222222, 1);

        // Random accesses.
        for (int t = 0; t < 40; t++) begin
            k = $urandom_range(0, 2);
            d = $urandom_range(0, TIMEOUT);
            run_txn(k != 1, k != 0, $urandom, $urandom, d, $urandom, 1'($urandom_range(0, 1)));
            idle($urandom_range(0, 2));
        end

        // Reset while a load is in WAIT, then a late ack for the aborted access.
        idle(1);
        mem_read = 1'b1; addr = 32'h60;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        #1 chk_all_zero("mid_wait_reset");
        m_rdata = '0; m_err = 1'b0; m_cnt = 0;
        @(posedge clk); #1;
        mem_read = 1'b0;
        rst = 1'b0;
        mem_ack = 1'b1; mem_rdata = 32'hFEEDFACE;
        @(posedge clk); #1;
        mem_ack = 1'b0;
        chk_all_zero("late_ack");
        @(posedge clk); #1;
        chk_all_zero("late_ack_next");

        // Normal operation resumes after reset.
        run_txn(1, 0, 32'h64, 32'h0, 2, 32'h5A5A5A5A, 0);
        idle(3);
        chk("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mem_stall_ctrl.md
MEM_STALL_CTRL -- requirements
Module: mem_stall_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 255: maximum WAIT cycles before an access is abandoned.
REQ-002 Parameter CNT_W, default 16: width of the stall performance counter.
REQ-003 clk_i  input  1  single clock; all state updates on posedge.
REQ-004 rst_i  input  1  reset, asynchronous, active-high.
REQ-005 MemRead_i  input  1  load pending in EX/MEM stage.
REQ-006 MemWrite_i  input  1  store pending in EX/MEM stage.
REQ-007 addr_i  input  32  EX/MEM ALU result (data address).
REQ-008 wdata_i  input  32  EX/MEM store data.
REQ-009 mem_ack_i  input  1  data memory completion, one-cycle pulse.
REQ-010 mem_rdata_i  input  32  data memory read data, valid with mem_ack_i.
REQ-011 mem_req_o  output  1  registered request to data memory.
REQ-012 mem_we_o  output  1  registered write enable; 1 = store.
REQ-013 mem_addr_o  output  32  registered, latched address.
REQ-014 mem_wdata_o  output  32  registered, latched store data.
REQ-015 stall_o  output  1  combinational hold for PC, IF/ID, ID/EX, EX/MEM registers.
REQ-016 rdata_o  output  32  load data toward MEM/WB.
REQ-017 err_o  output  1  sticky timeout flag.
REQ-018 stall_cnt_o  output  CNT_W  saturating count of cycles with stall_o=1.

Function
REQ-019 The FSM SHALL have exactly three states: IDLE, WAIT, DONE.
REQ-020 In IDLE, with MemRead_i|MemWrite_i=1: stall_o=1 in that same cycle; at posedge latch addr_i, wdata_i, and we=MemWrite_i; set mem_req_o=1; go to WAIT.
REQ-021 In IDLE with no access: stall_o=0; mem_req_o stays 0; remain in IDLE.
REQ-022 MemRead_i and MemWrite_i both 1 SHALL be treated as a store: mem_we_o=1, err_o unaffected.
REQ-023 In WAIT: stall_o=1; mem_req_o, mem_we_o, mem_addr_o, and mem_wdata_o are held constant; the wait counter increments each cycle.
REQ-024 In WAIT with mem_ack_i=1: at posedge clear mem_req_o; if the access is a load, load mem_rdata_i into rdata_o; go to DONE.
REQ-025 In WAIT with no ack and wait counter = TIMEOUT-1: at posedge clear mem_req_o; set err_o; if the access is a load, set rdata_o=0; go to DONE.
REQ-026 mem_ack_i arriving in the same cycle as the timeout condition SHALL win: data is taken and err_o is not set.
REQ-027 In DONE: stall_o=0 so the pipeline advances one instruction; unconditionally return to IDLE; inputs are not sampled for a new access.
REQ-028 mem_ack_i in IDLE or DONE SHALL be ignored.
REQ-029 rdata_o SHALL hold its value until the next load completion.
REQ-030 err_o SHALL remain set until reset.
REQ-031 The wait counter SHALL clear on entry to WAIT.
REQ-032 stall_cnt_o SHALL increment on each posedge where stall_o=1 and SHALL saturate at all-ones.
REQ-033 Latency: access seen in IDLE cycle N gives mem_req_o=1 from N+1; ack in cycle M gives DONE at M+1; minimum stall is 2 cycles.

Reset
REQ-034 While rst_i=1, asynchronously: state=IDLE; mem_req_o, mem_we_o, err_o = 0; mem_addr_o, mem_wdata_o, rdata_o = 0; stall_cnt_o = 0; wait counter = 0.
REQ-035 Reset during WAIT SHALL drop mem_req_o immediately; a later mem_ack_i for the aborted access is ignored (REQ-028).
REQ-036 stall_o SHALL be 0 while rst_i=1.

Verification
REQ-037 Load 0x40, ack after 3 WAIT cycles with 0xDEADBEEF -> stall_o high 4 cycles; mem_addr_o=0x40, mem_we_o=0; rdata_o=0xDEADBEEF in DONE; stall_cnt_o=4.
REQ-038 Store 0x44 data 0x12345678, ack after 1 WAIT cycle -> mem_we_o=1, mem_wdata_o=0x12345678; stall_o high 2 cycles; rdata_o unchanged.
REQ-039 Load, no ack, TIMEOUT=4 -> mem_req_o drops after 4 WAIT cycles; err_o=1; rdata_o=0; err_o stays 1 across later accesses.
REQ-040 MemRead_i=MemWrite_i=1 -> treated as store (mem_we_o=1).
REQ-041 Back-to-back loads -> exactly one DONE cycle with stall_o=0 between them; stray ack in DONE ignored.
REQ-042 rst_i pulsed mid-WAIT, then late ack -> all outputs 0, FSM stays IDLE, ack ignored.
